square_object_mover: RTL and testbench



---
 rtl/obj_pkg.sv | 53 +++++
 rtl/obj_hit_test.sv | 36 +++
 rtl/square_object_mover.sv | 142 ++++++++++++++
 tb/tb_square_object_mover.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/obj_pkg.sv
// Shared types and constants for the bouncing square sprite.
// Includes the per-axis step-and-bounce helper used by the mover FSM.
package obj_pkg;

  localparam int COORD_W      = 11;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_X,
    MOVE_Y
  } mover_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic               dir;
    logic               flip;
  } axis_step_t;

  // One frame of motion on one axis; max_pos is screen size minus object size.
  // All comparisons are COORD_W+1 bits wide so the sum can never wrap.
  function automatic axis_step_t step_axis(
    input logic [COORD_W-1:0] pos,
    input logic               dir,
    input logic [COORD_W:0]   speed,
    input logic [COORD_W:0]   max_pos
  );
    axis_step_t r;
    r.pos  = pos;
    r.dir  = dir;
    r.flip = 1'b0;
    if (dir) begin
      if ({1'b0, pos} + speed > max_pos) begin
        r.pos  = max_pos[COORD_W-1:0];
        r.dir  = 1'b0;
        r.flip = 1'b1;
      end else begin
        r.pos = pos + speed[COORD_W-1:0];
      end
    end else begin
      if ({1'b0, pos} < speed) begin
        r.pos  = '0;
        r.dir  = 1'b1;
        r.flip = 1'b1;
      end else begin
        r.pos = pos - speed[COORD_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/obj_hit_test.sv
// Combinational rectangle test: is the current pixel inside the object box?
// With OBJ_OUTLINE_EN defined, also flags pixels on the 1-pixel perimeter.
module obj_hit_test
  import obj_pkg::*;
#(
  parameter int OBJ_W = 32,
  parameter int OBJ_H = 32
) (
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic [COORD_W-1:0] topLeftX,
  input  logic [COORD_W-1:0] topLeftY,
`ifdef OBJ_OUTLINE_EN
  output logic               on_edge,
`endif
  output logic               hit
);

  logic [COORD_W:0] px, py, tlx, tly;
  logic             in_x, in_y;

  assign px  = {1'b0, pixelX};
  assign py  = {1'b0, pixelY};
  assign tlx = {1'b0, topLeftX};
  assign tly = {1'b0, topLeftY};

  assign in_x = (px >= tlx) && (px < tlx + (COORD_W+1)'(OBJ_W));
  assign in_y = (py >= tly) && (py < tly + (COORD_W+1)'(OBJ_H));
  assign hit  = in_x && in_y;

`ifdef OBJ_OUTLINE_EN
  assign on_edge = hit && ((px == tlx) || (px == tlx + (COORD_W+1)'(OBJ_W - 1)) ||
                           (py == tly) || (py == tly + (COORD_W+1)'(OBJ_H - 1)));
`endif

endmodule

// File: rtl/square_object_mover.sv
// Frame-synchronous bouncing rectangle sprite feeding the VGA colour input.
// Optional OBJ_OUTLINE_EN macro draws the object perimeter in inverted colour.
module square_object_mover
  import obj_pkg::*;
#(
  parameter int         SCREEN_W  = SCREEN_W_DEF,
  parameter int         SCREEN_H  = SCREEN_H_DEF,
  parameter int         OBJ_W     = 32,
  parameter int         OBJ_H     = 32,
  parameter int         INIT_X    = 0,
  parameter int         INIT_Y    = 0,
  parameter int         SPEED_X   = 2,
  parameter int         SPEED_Y   = 1,
  parameter logic [7:0] OBJ_COLOR = 8'hE0,
  parameter logic [7:0] BG_COLOR  = 8'h00
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               startOfFrame,
  input  logic               pause,
  output logic [7:0]         RGBout,
  output logic               drawingRequest,
  output logic               bounce,
  output logic [COORD_W-1:0] topLeftX,
  output logic [COORD_W-1:0] topLeftY
);

  localparam logic [COORD_W:0]   MAX_X = (COORD_W+1)'(SCREEN_W - OBJ_W);
  localparam logic [COORD_W:0]   MAX_Y = (COORD_W+1)'(SCREEN_H - OBJ_H);
  localparam logic [COORD_W:0]   SPD_X = (COORD_W+1)'(SPEED_X);
  localparam logic [COORD_W:0]   SPD_Y = (COORD_W+1)'(SPEED_Y);
  localparam logic [COORD_W-1:0] RST_X = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] RST_Y = COORD_W'(INIT_Y);

  mover_state_t       state_reg, state_next;
  logic [COORD_W-1:0] x_reg, x_next, y_reg, y_next;
  logic               dir_x_reg, dir_x_next, dir_y_reg, dir_y_next;
  logic               bounce_reg, bounce_next;
  logic [7:0]         rgb_reg, rgb_next;
  logic               draw_reg;
  logic               hit;
  axis_step_t         step_x, step_y;

  assign step_x = step_axis(x_reg, dir_x_reg, SPD_X, MAX_X);
  assign step_y = step_axis(y_reg, dir_y_reg, SPD_Y, MAX_Y);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg  <= IDLE;
      x_reg      <= RST_X;
      y_reg      <= RST_Y;
      dir_x_reg  <= 1'b1;
      dir_y_reg  <= 1'b1;
      bounce_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      dir_x_reg  <= dir_x_next;
      dir_y_reg  <= dir_y_next;
      bounce_reg <= bounce_next;
    end
  end

  // startOfFrame is only looked at in IDLE, so a frame in progress always completes.
  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    dir_x_next  = dir_x_reg;
    dir_y_next  = dir_y_reg;
    bounce_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (startOfFrame && !pause) state_next = MOVE_X;
      end
      MOVE_X: begin
        x_next      = step_x.pos;
        dir_x_next  = step_x.dir;
        bounce_next = step_x.flip;
        state_next  = MOVE_Y;
      end
      MOVE_Y: begin
        y_next      = step_y.pos;
        dir_y_next  = step_y.dir;
        bounce_next = step_y.flip;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef OBJ_OUTLINE_EN
  logic on_edge;

  obj_hit_test #(.OBJ_W(OBJ_W), .OBJ_H(OBJ_H)) u_hit (
    .pixelX  (pixelX),
    .pixelY  (pixelY),
    .topLeftX(x_reg),
    .topLeftY(y_reg),
    .on_edge (on_edge),
    .hit     (hit)
  );

  always_comb begin
    rgb_next = BG_COLOR;
    if (hit) rgb_next = on_edge ? ~OBJ_COLOR : OBJ_COLOR;
  end
`else
  obj_hit_test #(.OBJ_W(OBJ_W), .OBJ_H(OBJ_H)) u_hit (
    .pixelX  (pixelX),
    .pixelY  (pixelY),
    .topLeftX(x_reg),
    .topLeftY(y_reg),
    .hit     (hit)
  );

  always_comb begin
    rgb_next = BG_COLOR;
    if (hit) rgb_next = OBJ_COLOR;
  end
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rgb_reg  <= BG_COLOR;
      draw_reg <= 1'b0;
    end else begin
      rgb_reg  <= rgb_next;
      draw_reg <= hit;
    end
  end

  assign RGBout         = rgb_reg;
  assign drawingRequest = draw_reg;
  assign bounce         = bounce_reg;
  assign topLeftX       = x_reg;
  assign topLeftY       = y_reg;

endmodule

// File: tb/tb_square_object_mover.sv
// Directed bench for square_object_mover: three instances cover centre motion,
// right-edge bounce and corner bounce with asynchronous reset mid-update.
module tb_square_object_mover;

`ifdef OBJ_OUTLINE_EN
  localparam logic [7:0] EDGE_RGB = 8'h1F;
`else
  localparam logic [7:0] EDGE_RGB = 8'hE0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] px, py;
  logic        pause;
  logic        sof_a, sof_b, sof_c;
  logic        rn_a, rn_b, rn_c;

  logic [7:0]  rgb_a, rgb_b, rgb_c;
  logic        draw_a, draw_b, draw_c;
  logic        bnc_a, bnc_b, bnc_c;
  logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;

  square_object_mover dut_a (
    .clk(clk), .resetN(rn_a), .pixelX(px), .pixelY(py), .startOfFrame(sof_a),
    .pause(pause), .RGBout(rgb_a), .drawingRequest(draw_a), .bounce(bnc_a),
    .topLeftX(x_a), .topLeftY(y_a)
  );

  square_object_mover #(.INIT_X(606)) dut_b (
    .clk(clk), .resetN(rn_b), .pixelX(px), .pixelY(py), .startOfFrame(sof_b),
    .pause(pause), .RGBout(rgb_b), .drawingRequest(draw_b), .bounce(bnc_b),
    .topLeftX(x_b), .topLeftY(y_b)
  );

  square_object_mover #(.INIT_X(608), .INIT_Y(448)) dut_c (
    .clk(clk), .resetN(rn_c), .pixelX(px), .pixelY(py), .startOfFrame(sof_c),
    .pause(pause), .RGBout(rgb_c), .drawingRequest(draw_c), .bounce(bnc_c),
    .topLeftX(x_c), .topLeftY(y_c)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int bcnt_a  = 0;
  int bcnt_b  = 0;

  always @(negedge clk) begin
    if (bnc_a === 1'b1) bcnt_a++;
    if (bnc_b === 1'b1) bcnt_b++;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end else begin
      $display("ok   %s: %0d", name, actual);
    end
  endtask

  // which: 0=A 1=B 2=C; hi = number of cycles startOfFrame stays high
  task automatic frame(input int which, input int hi);
    @(negedge clk);
    case (which)
      0: sof_a = 1'b1;
      1: sof_b = 1'b1;
      default: sof_c = 1'b1;
    endcase
    repeat (hi) @(negedge clk);
    sof_a = 1'b0;
    sof_b = 1'b0;
    sof_c = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic        draw;
    logic [7:0]  rgb;
  } pix_vec_t;

  pix_vec_t vecs [8];

  initial begin
    vecs[0] = '{11'd0,   11'd0,   1'b1, EDGE_RGB};
    vecs[1] = '{11'd31,  11'd31,  1'b1, EDGE_RGB};
    vecs[2] = '{11'd32,  11'd0,   1'b0, 8'h00};
    vecs[3] = '{11'd0,   11'd32,  1'b0, 8'h00};
    vecs[4] = '{11'd15,  11'd15,  1'b1, 8'hE0};
    vecs[5] = '{11'd31,  11'd10,  1'b1, EDGE_RGB};
    vecs[6] = '{11'd10,  11'd0,   1'b1, EDGE_RGB};
    vecs[7] = '{11'd639, 11'd479, 1'b0, 8'h00};

    px = 11'd5; py = 11'd5; pause = 1'b0;
    sof_a = 1'b0; sof_b = 1'b0; sof_c = 1'b0;
    rn_a = 1'b0; rn_b = 1'b0; rn_c = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_x",      32'(x_a),    32'd0);
    check("rst_y",      32'(y_a),    32'd0);
    check("rst_rgb",    32'(rgb_a),  32'h00);
    check("rst_draw",   32'(draw_a), 32'd0);
    check("rst_bounce", 32'(bnc_a),  32'd0);
    check("rst_c_x",    32'(x_c),    32'd608);
    rn_a = 1'b1; rn_b = 1'b1; rn_c = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      px = vecs[i].x; py = vecs[i].y;
      @(posedge clk); #1;
      check($sformatf("pix%0d_draw", i), 32'(draw_a), 32'(vecs[i].draw));
      check($sformatf("pix%0d_rgb", i),  32'(rgb_a),  32'(vecs[i].rgb));
      @(negedge clk);
    end

    // Output must hold the previous pixel's result until the next edge.
    px = 11'd15; py = 11'd15;
    @(posedge clk); #1;
    @(negedge clk);
    px = 11'd200; py = 11'd200;
    #1;
    check("lat_hold_draw", 32'(draw_a), 32'd1);
    @(posedge clk); #1;
    check("lat_next_draw", 32'(draw_a), 32'd0);

    for (int f = 0; f < 10; f++) frame(0, 1);
    check("ten_x",      32'(x_a),   32'd20);
    check("ten_y",      32'(y_a),   32'd10);
    check("ten_bounce", 32'(bcnt_a), 32'd0);

    pause = 1'b1;
    for (int f = 0; f < 5; f++) frame(0, 1);
    check("pause_x", 32'(x_a), 32'd20);
    check("pause_y", 32'(y_a), 32'd10);
    pause = 1'b0;
    frame(0, 1);
    check("resume_x", 32'(x_a), 32'd22);
    check("resume_y", 32'(y_a), 32'd11);

    // startOfFrame held across MOVE_X/MOVE_Y must not trigger a second move.
    frame(0, 3);
    check("busy_sof_x", 32'(x_a), 32'd24);
    check("busy_sof_y", 32'(y_a), 32'd12);

    px = 11'd24; py = 11'd17;
    @(posedge clk); #1;
    check("left_col_draw", 32'(draw_a), 32'd1);
    check("left_col_rgb",  32'(rgb_a),  32'(EDGE_RGB));
    @(negedge clk);
    px = 11'd29; py = 11'd17;
    @(posedge clk); #1;
    check("interior_rgb", 32'(rgb_a), 32'hE0);

    frame(1, 1);
    check("b_f1_x",      32'(x_b),    32'd608);
    check("b_f1_y",      32'(y_b),    32'd1);
    check("b_f1_bounce", 32'(bcnt_b), 32'd0);
    frame(1, 1);
    check("b_f2_x",      32'(x_b),    32'd608);
    check("b_f2_bounce", 32'(bcnt_b), 32'd1);
    frame(1, 1);
    check("b_f3_x",      32'(x_b),    32'd606);
    check("b_f3_y",      32'(y_b),    32'd3);

    // Corner hit: bounce in the MOVE_X and MOVE_Y result cycles back to back.
    @(negedge clk); sof_c = 1'b1;
    @(negedge clk); sof_c = 1'b0;
    check("c_bnc_before", 32'(bnc_c), 32'd0);
    @(negedge clk);
    check("c_bnc_x",      32'(bnc_c), 32'd1);
    check("c_x_clamp",    32'(x_c),   32'd608);
    @(negedge clk);
    check("c_bnc_y",      32'(bnc_c), 32'd1);
    check("c_y_clamp",    32'(y_c),   32'd448);
    @(negedge clk);
    check("c_bnc_after",  32'(bnc_c), 32'd0);

    // Next frame moves left/up; reset lands while the FSM is in MOVE_Y.
    @(negedge clk); sof_c = 1'b1;
    @(negedge clk); sof_c = 1'b0;
    @(negedge clk);
    check("c_x_left", 32'(x_c), 32'd606);
    rn_c = 1'b0;
    #1;
    check("c_rst_x",      32'(x_c),   32'd608);
    check("c_rst_y",      32'(y_c),   32'd448);
    check("c_rst_bounce", 32'(bnc_c), 32'd0);
    @(negedge clk); rn_c = 1'b1;
    @(negedge clk); sof_c = 1'b1;
    @(negedge clk); sof_c = 1'b0;
    @(negedge clk);
    check("c_post_bnc", 32'(bnc_c), 32'd1);
    repeat (3) @(negedge clk);
    check("c_post_x", 32'(x_c), 32'd608);
    check("c_post_y", 32'(y_c), 32'd448);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
